matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_pkg.sv | 28 ++
 rtl/matmul_index_gen.sv | 65 ++++++
 rtl/matmul_sequencer.sv | 144 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply address sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_MAX_M = 4;
    localparam int DEF_MAX_N = 4;
    localparam int DEF_MAX_P = 4;

    // Width of a dimension value that must be able to hold 0..max.
    function automatic int dw(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Width of an index 0..max-1; never narrower than one bit.
    function automatic int iw(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/matmul_index_gen.sv
// Nested i/j/k wrap counter: k innermost, then j, then i (row-major over C).
// Latency: indices update one cycle after a step; last flags are combinational from the counters.
// Backpressure: none; counters only move when stepped, clear wins over any step.
module matmul_index_gen
    import matmul_pkg::*;
#(
    parameter int MAX_M = DEF_MAX_M,
    parameter int MAX_N = DEF_MAX_N,
    parameter int MAX_P = DEF_MAX_P,
    localparam int DW_M = dw(MAX_M),
    localparam int DW_N = dw(MAX_N),
    localparam int DW_P = dw(MAX_P),
    localparam int IW_M = iw(MAX_M),
    localparam int IW_N = iw(MAX_N),
    localparam int IW_P = iw(MAX_P)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            step_k,
    input  logic            step_ij,
    input  logic [DW_M-1:0] lim_m,
    input  logic [DW_N-1:0] lim_n,
    input  logic [DW_P-1:0] lim_p,
    output logic [IW_M-1:0] i,
    output logic [IW_P-1:0] j,
    output logic [IW_N-1:0] k,
    output logic            last_k,
    output logic            last_ij
);

    logic last_i;
    logic last_j;

    assign last_k  = (DW_N'(k) == lim_n - DW_N'(1));
    assign last_j  = (DW_P'(j) == lim_p - DW_P'(1));
    assign last_i  = (DW_M'(i) == lim_m - DW_M'(1));
    assign last_ij = last_i && last_j;

    // Counter state: k wraps each dot product, j/i advance per C element and fully wrap after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (step_k) begin
                k <= last_k ? '0 : k + IW_N'(1);
            end
            if (step_ij) begin
                if (last_j) begin
                    j <= '0;
                    i <= last_i ? '0 : i + IW_M'(1);
                end else begin
                    j <= j + IW_P'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences A/B reads, MAC control and C writes for C = A x B, row-major, n+2 cycles per C element.
// Latency: ISSUE one cycle after start; mac strobes trail reads by one cycle; done m*p*(n+2)+1 after start.
// Backpressure: none; abort cancels a run at any point, start is only honoured in IDLE.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int MAX_M = DEF_MAX_M,
    parameter int MAX_N = DEF_MAX_N,
    parameter int MAX_P = DEF_MAX_P,
    localparam int DW_M = dw(MAX_M),
    localparam int DW_N = dw(MAX_N),
    localparam int DW_P = dw(MAX_P),
    localparam int IW_M = iw(MAX_M),
    localparam int IW_N = iw(MAX_N),
    localparam int IW_P = iw(MAX_P)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [DW_M-1:0] dim_m,
    input  logic [DW_N-1:0] dim_n,
    input  logic [DW_P-1:0] dim_p,
    output logic            a_rd,
    output logic [IW_M-1:0] a_row,
    output logic [IW_N-1:0] a_col,
    output logic            b_rd,
    output logic [IW_N-1:0] b_row,
    output logic [IW_P-1:0] b_col,
    output logic            mac_en,
    output logic            mac_load,
    output logic            c_wr,
    output logic [IW_M-1:0] c_row,
    output logic [IW_P-1:0] c_col,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_t          state_q;
    state_t          state_d;
    logic [DW_M-1:0] m_q;
    logic [DW_N-1:0] n_q;
    logic [DW_P-1:0] p_q;
    logic            dims_ok;
    logic            accept;
    logic            reject;
    logic            clear;
    logic            step_k;
    logic            step_ij;
    logic            last_k;
    logic            last_ij;
    logic [IW_M-1:0] i;
    logic [IW_P-1:0] j;
    logic [IW_N-1:0] k;

    assign dims_ok = (dim_m != '0) && (dim_m <= DW_M'(MAX_M)) &&
                     (dim_n != '0) && (dim_n <= DW_N'(MAX_N)) &&
                     (dim_p != '0) && (dim_p <= DW_P'(MAX_P));
    // Abort alongside start in IDLE suppresses both the run and the error pulse.
    assign accept  = (state_q == ST_IDLE) && start && !abort && dims_ok;
    assign reject  = (state_q == ST_IDLE) && start && !abort && !dims_ok;
    assign clear   = accept || ((state_q != ST_IDLE) && abort);
    assign step_k  = (state_q == ST_ISSUE) && !abort;
    assign step_ij = (state_q == ST_WRITE) && !abort;

    matmul_index_gen #(
        .MAX_M (MAX_M),
        .MAX_N (MAX_N),
        .MAX_P (MAX_P)
    ) u_index_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .step_k  (step_k),
        .step_ij (step_ij),
        .lim_m   (m_q),
        .lim_n   (n_q),
        .lim_p   (p_q),
        .i       (i),
        .j       (j),
        .k       (k),
        .last_k  (last_k),
        .last_ij (last_ij)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ISSUE runs n cycles, one DRAIN for the read latency, one WRITE, abort wins everywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: if (abort) state_d = ST_IDLE;
                      else if (last_k) state_d = ST_DRAIN;
            ST_DRAIN: state_d = abort ? ST_IDLE : ST_WRITE;
            ST_WRITE: if (abort) state_d = ST_IDLE;
                      else state_d = last_ij ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Dimension latch, MAC strobes delayed one cycle behind the reads, and the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q      <= '0;
            n_q      <= '0;
            p_q      <= '0;
            mac_en   <= 1'b0;
            mac_load <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                m_q <= dim_m;
                n_q <= dim_n;
                p_q <= dim_p;
            end
            mac_en   <= step_k;
            mac_load <= step_k && (k == '0);
            err      <= reject;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign a_rd  = (state_q == ST_ISSUE);
    assign b_rd  = (state_q == ST_ISSUE);
    assign c_wr  = (state_q == ST_WRITE);
    assign a_row = a_rd ? i : '0;
    assign a_col = a_rd ? k : '0;
    assign b_row = b_rd ? k : '0;
    assign b_col = b_rd ? j : '0;
    assign c_row = c_wr ? i : '0;
    assign c_col = c_wr ? j : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomised directed bench for matmul_sequencer against a cycle-position reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_matmul_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] dim_m;
    logic [2:0] dim_n;
    logic [2:0] dim_p;
    logic       a_rd;
    logic [1:0] a_row;
    logic [1:0] a_col;
    logic       b_rd;
    logic [1:0] b_row;
    logic [1:0] b_col;
    logic       mac_en;
    logic       mac_load;
    logic       c_wr;
    logic [1:0] c_row;
    logic [1:0] c_col;
    logic       busy;
    logic       done;
    logic       err;

    int n_total;
    int n_pass;
    int a_mem [4][4];
    int b_mem [4][4];

    matmul_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .dim_m    (dim_m),
        .dim_n    (dim_n),
        .dim_p    (dim_p),
        .a_rd     (a_rd),
        .a_row    (a_row),
        .a_col    (a_col),
        .b_rd     (b_rd),
        .b_row    (b_row),
        .b_col    (b_col),
        .mac_en   (mac_en),
        .mac_load (mac_load),
        .c_wr     (c_wr),
        .c_row    (c_row),
        .c_col    (c_col),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] observed();
        return {busy, a_rd, a_row, a_col, b_rd, b_row, b_col,
                mac_en, mac_load, c_wr, c_row, c_col, done, err};
    endfunction

    // Expected outputs c cycles after start was sampled, from timing arithmetic alone.
    function automatic logic [19:0] expected(int m, int n, int p, int c);
        logic       bz, ard, me, ml, cw, dn;
        logic [1:0] ar, ac, br, bc, cr, cc;
        int         total, e, r, ii, jj;
        bz = 0; ard = 0; me = 0; ml = 0; cw = 0; dn = 0;
        ar = 0; ac = 0; br = 0; bc = 0; cr = 0; cc = 0;
        total = m * p * (n + 2);
        if (c >= 1 && c <= total) begin
            e  = (c - 1) / (n + 2);
            r  = (c - 1) % (n + 2);
            ii = e / p;
            jj = e % p;
            bz = 1;
            if (r < n) begin
                ard = 1; ar = 2'(ii); ac = 2'(r); br = 2'(r); bc = 2'(jj);
            end
            if (r >= 1 && r <= n) begin
                me = 1; ml = (r == 1);
            end
            if (r == n + 1) begin
                cw = 1; cr = 2'(ii); cc = 2'(jj);
            end
        end else if (c == total + 1) begin
            bz = 1; dn = 1;
        end
        return {bz, ard, ar, ac, ard, br, bc, me, ml, cw, cr, cc, dn, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    // Start a run at the current negedge and check every cycle; abort_at=0 means run to completion.
    task automatic run(input int m, input int n, input int p, input int abort_at);
        int          total, last;
        int          cnt_en, cnt_ld, cnt_wr;
        int          acc, prod, ref_c;
        int          cm [4][4];
        logic [19:0] want;
        total = m * p * (n + 2);
        last  = (abort_at != 0) ? abort_at + 4 : total + 3;
        cnt_en = 0; cnt_ld = 0; cnt_wr = 0; acc = 0; prod = 0;
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++) cm[r][s] = -1;
        dim_m = 3'(m); dim_n = 3'(n); dim_p = 3'(p);
        start = 1'b1;
        abort = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            want = (abort_at != 0 && c > abort_at) ? 20'd0 : expected(m, n, p, c);
            chk($sformatf("run%0dx%0dx%0d_cyc%0d", m, n, p, c), 32'(observed()), 32'(want));
            if (mac_en) begin
                acc = mac_load ? prod : acc + prod;
                cnt_en++;
                if (mac_load) cnt_ld++;
            end
            if (c_wr) begin
                cm[c_row][c_col] = acc;
                cnt_wr++;
            end
            if (a_rd) prod = a_mem[a_row][a_col] * b_mem[b_row][b_col];
            dim_m = 3'($urandom_range(0, 7));
            dim_n = 3'($urandom_range(0, 7));
            dim_p = 3'($urandom_range(0, 7));
            start = (c <= total) && (abort_at == 0 || c < abort_at) && ($urandom_range(0, 3) == 0);
            abort = (c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
        if (abort_at == 0) begin
            chk($sformatf("mac_en_count_%0dx%0dx%0d", m, n, p), 32'(cnt_en), 32'(m * n * p));
            chk($sformatf("mac_load_count_%0dx%0dx%0d", m, n, p), 32'(cnt_ld), 32'(m * p));
            chk($sformatf("c_wr_count_%0dx%0dx%0d", m, n, p), 32'(cnt_wr), 32'(m * p));
            for (int r = 0; r < m; r++) begin
                for (int s = 0; s < p; s++) begin
                    ref_c = 0;
                    for (int t = 0; t < n; t++) ref_c += a_mem[r][t] * b_mem[t][s];
                    chk($sformatf("c_val_%0d_%0d", r, s), 32'(cm[r][s]), 32'(ref_c));
                end
            end
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        dim_m = 3'd0; dim_n = 3'd0; dim_p = 3'd0;
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++) begin
                a_mem[r][s] = int'($urandom_range(0, 255));
                b_mem[r][s] = int'($urandom_range(0, 255));
            end

        // Reset state.
        #12;
        @(negedge clk);
        chk("reset_outputs", 32'(observed()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 32'(observed()), 32'd0);

        // Smallest run, then the 2x3x2 reference case.
        run(1, 1, 1, 0);
        run(2, 3, 2, 0);

        // Bad dimensions: n=0, then m above its maximum.
        dim_m = 3'd2; dim_n = 3'd0; dim_p = 3'd2; start = 1'b1;
        @(negedge clk);
        chk("err_n0_pulse", 32'({err, busy, a_rd}), 32'(3'b100));
        start = 1'b0;
        @(negedge clk);
        chk("err_n0_clear", 32'({err, busy, a_rd}), 32'(3'b000));
        dim_m = 3'd5; dim_n = 3'd2; dim_p = 3'd2; start = 1'b1;
        @(negedge clk);
        chk("err_m5_pulse", 32'({err, busy, a_rd}), 32'(3'b100));
        start = 1'b0;
        @(negedge clk);
        chk("err_m5_clear", 32'({err, busy, a_rd}), 32'(3'b000));

        // Start together with abort in IDLE: nothing happens, neither for good nor bad dims.
        dim_m = 3'd2; dim_n = 3'd2; dim_p = 3'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("start_abort_idle_ok", 32'(observed()), 32'd0);
        dim_n = 3'd0;
        @(negedge clk);
        chk("start_abort_idle_bad", 32'(observed()), 32'd0);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_after", 32'(observed()), 32'd0);

        // Abort mid-run, then a normal run.
        run(2, 3, 2, 7);
        run(2, 3, 2, 0);

        // Asynchronous reset in the middle of ISSUE, start accepted on the first cycle after release.
        dim_m = 3'd2; dim_n = 3'd3; dim_p = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_reset_issue", 32'({busy, a_rd}), 32'(2'b11));
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(observed()), 32'd0);
        @(negedge clk);
        chk("held_reset_outputs", 32'(observed()), 32'd0);
        rst_n = 1'b1;
        run(3, 2, 4, 0);

        // Full-size run and a few random shapes.
        run(4, 4, 4, 0);
        for (int t = 0; t < 4; t++) begin
            run($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
